// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder/subtractor, DIGIT bits per clock, WIDTH-bit result
// Result and flags are registered only on entry to DONE, so the ports never show partial sums.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic [DIGIT:0]   w_dsum;
  logic             w_cmsb;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  assign w_da   = r_a[DIGIT-1:0];
  assign w_db   = r_b[DIGIT-1:0];
  assign w_dsum = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the digit MSB recovered from its sum bit; on the last digit this is the carry into bit WIDTH-1.
  assign w_cmsb = w_da[DIGIT-1] ^ w_db[DIGIT-1] ^ w_dsum[DIGIT-1];
  assign w_last = (r_cnt == CW'(NDIG - 1));
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= sub | cin;
        r_acc   <= '0;
        r_cnt   <= '0;
      end
    end else if (r_state == RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_dsum[DIGIT];
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_s    <= w_acc_next;
        r_cout <= w_dsum[DIGIT];
        r_ovf  <= w_dsum[DIGIT] ^ w_cmsb;
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
